// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR word generator with a valid/ready output slot.
// Seed and tap mask can be reloaded at run time; loads flush the output slot.
module lfsr_gen #(
  parameter int unsigned          WIDTH = 32,
  parameter logic [WIDTH-1:0]     TAPS  = WIDTH'(32'h0040_0007),
  parameter logic [WIDTH-1:0]     SEED  = '1,
  parameter int unsigned          STEPS = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             taps_load,
  input  logic [WIDTH-1:0] taps_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] taps_q,  taps_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;

  logic             slot_free;
  logic             any_load;

  // STEPS Galois shifts unrolled; each step is one XOR level per tapped bit.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s,
                                               input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] r;
    r = s;
    for (int unsigned i = 0; i < STEPS; i++) begin
      r = {r[WIDTH-2:0], 1'b0} ^ (r[WIDTH-1] ? t : '0);
    end
    return r;
  endfunction

  assign slot_free = !valid_q || out_ready;
  assign any_load  = seed_load || taps_load;

  always_comb begin
    state_d  = state_q;
    taps_d   = taps_q;
    data_d   = data_q;
    valid_d  = valid_q;
    lockup_d = lockup_q;

    if (any_load) begin
      // A word presented alongside a load is dropped even if out_ready is high.
      valid_d = 1'b0;
      if (seed_load) begin
        if (seed_in != '0) begin
          state_d  = seed_in;
          lockup_d = 1'b0;
        end else begin
          state_d  = SEED;
          lockup_d = 1'b1;
        end
      end
      if (taps_load) begin
        taps_d = taps_in | ONE;
      end
    end else if (slot_free) begin
      if (en) begin
        data_d  = state_q;
        state_d = advance(state_q, taps_q);
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= SEED;
      taps_q   <= TAPS | ONE;
      data_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      taps_q   <= taps_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: directed scenarios plus random traffic on a 10-bit
// instance against a polynomial-arithmetic model, and 32-bit default checks.
module tb_lfsr_gen;

  localparam int unsigned W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn, en, seed_load, taps_load, out_ready;
  logic [W-1:0] seed_in, taps_in, out_data;
  logic         out_valid, lockup;

  logic         en32;
  logic [31:0]  zero32;
  logic [31:0]  d32a, d32b;
  logic         v32a, v32b, l32a, l32b;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: word value as an integer, next value is s*x mod P(x).
  int unsigned m_state, m_taps, m_data;
  bit          m_valid, m_lock;

  logic [W-1:0] words [0:1023];

  lfsr_gen #(.WIDTH(10), .TAPS(10'h009), .SEED(10'h3ff), .STEPS(1)) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .seed_load(seed_load), .seed_in(seed_in),
    .taps_load(taps_load), .taps_in(taps_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .lockup(lockup)
  );

  lfsr_gen #(.WIDTH(32), .STEPS(1)) dut32a (
    .clk(clk), .rstn(rstn), .en(en32),
    .seed_load(1'b0), .seed_in(zero32),
    .taps_load(1'b0), .taps_in(zero32),
    .out_valid(v32a), .out_ready(1'b1),
    .out_data(d32a), .lockup(l32a)
  );

  lfsr_gen #(.WIDTH(32), .STEPS(2)) dut32b (
    .clk(clk), .rstn(rstn), .en(en32),
    .seed_load(1'b0), .seed_in(zero32),
    .taps_load(1'b0), .taps_in(zero32),
    .out_valid(v32b), .out_ready(1'b1),
    .out_data(d32b), .lockup(l32b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned mulx(input int unsigned s, input int unsigned t);
    int unsigned v;
    v = s * 2;
    if (v >= 1024) v = (v - 1024) ^ t;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 10'h3ff;
    m_taps  = 10'h009;
    m_data  = 0;
    m_valid = 0;
    m_lock  = 0;
  endtask

  task automatic model_edge();
    bit take;
    take = !m_valid || out_ready;
    if (seed_load || taps_load) begin
      m_valid = 0;
      if (seed_load) begin
        if (seed_in != 0) begin
          m_state = int'(seed_in);
          m_lock  = 0;
        end else begin
          m_state = 10'h3ff;
          m_lock  = 1;
        end
      end
      if (taps_load) m_taps = int'(taps_in) | 1;
    end else if (take) begin
      if (en) begin
        m_data  = m_state;
        m_state = mulx(m_state, m_taps);
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("valid", 64'(out_valid), 64'(m_valid));
    check("data", 64'(out_data), 64'(m_data));
    check("lockup", 64'(lockup), 64'(m_lock));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    en = 1'b0; seed_load = 1'b0; taps_load = 1'b0; out_ready = 1'b0;
    seed_in = '0; taps_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_lockup", 64'(lockup), 64'd0);
    rstn = 1'b1;
  endtask

  initial begin
    bit bad;
    zero32 = '0;
    en32 = 1'b0;

    // Reset, then a full period of the 10-bit sequence.
    do_reset();
    check("rst32_data", 64'(d32a), 64'd0);
    check("rst32_valid", 64'(v32a), 64'd0);
    en = 1'b1; out_ready = 1'b1; en32 = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      step();
      words[i] = out_data;
      if (i == 0) begin
        check("w32s1_0", 64'(d32a), 64'hffffffff);
        check("w32s2_0", 64'(d32b), 64'hffffffff);
      end
      if (i == 1) begin
        check("w32s1_1", 64'(d32a), 64'hffbffff9);
        check("w32s2_1", 64'(d32b), 64'hff3ffff5);
      end
    end
    check("seq0", 64'(words[0]), 64'h3ff);
    check("seq1", 64'(words[1]), 64'h3f7);
    check("seq2", 64'(words[2]), 64'h3e7);
    bad = 0;
    for (int i = 1; i < 1023; i++)
      if (words[i] == 10'h3ff || words[i] == 10'h000) bad = 1;
    check("period_inner", 64'(bad), 64'd0);
    check("period_wrap", 64'(words[1023]), 64'h3ff);

    // Stall for 5 cycles after the first word.
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    step();
    check("stall_first", 64'(out_data), 64'h3ff);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold", 64'(out_data), 64'h3ff);
    end
    out_ready = 1'b1;
    step();
    check("stall_resume", 64'(out_data), 64'h3f7);

    // Seed loads: normal, zero (lockup), then clearing.
    step(); step();
    seed_load = 1'b1; seed_in = 10'h155;
    step();
    check("seed_flush", 64'(out_valid), 64'd0);
    seed_load = 1'b0;
    step();
    check("seed_word", 64'(out_data), 64'h155);
    seed_load = 1'b1; seed_in = 10'h000;
    step();
    check("lockup_set", 64'(lockup), 64'd1);
    seed_load = 1'b0;
    step();
    check("lockup_word", 64'(out_data), 64'h3ff);
    step(); step();
    seed_load = 1'b1; seed_in = 10'h001;
    step();
    check("lockup_clr", 64'(lockup), 64'd0);
    seed_load = 1'b0;
    step();

    // Simultaneous taps and seed load; taps bit 0 forced.
    taps_load = 1'b1; taps_in = 10'h008; seed_load = 1'b1; seed_in = 10'h200;
    step();
    taps_load = 1'b0; seed_load = 1'b0;
    step();
    check("taps_w0", 64'(out_data), 64'h200);
    step();
    check("taps_w1", 64'(out_data), 64'h009);

    // Enable toggling with the consumer always ready.
    en = 1'b0;
    step();
    check("en_off0", 64'(out_valid), 64'd0);
    step();
    check("en_off1", 64'(out_valid), 64'd0);
    en = 1'b1;
    step();
    check("en_on", 64'(out_valid), 64'd1);

    // Random traffic, including loads and zero seeds.
    for (int i = 0; i < 800; i++) begin
      en        = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      seed_load = ($urandom_range(0, 19) == 0);
      taps_load = ($urandom_range(0, 19) == 0);
      seed_in   = ($urandom_range(0, 9) == 0) ? 10'h000 : W'($urandom_range(1, 1023));
      taps_in   = W'($urandom);
      step();
    end
    seed_load = 1'b0; taps_load = 1'b0;

    // Asynchronous reset in the middle of a stall, with lockup set.
    seed_load = 1'b1; seed_in = '0; en = 1'b1; out_ready = 1'b0;
    step();
    seed_load = 1'b0;
    step();
    step();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_lock", 64'(lockup), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_data", 64'(out_data), 64'd0);
    check("async_lockup", 64'(lockup), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_word", 64'(out_data), 64'h3ff);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Galois LFSR pseudo-random word generator with a valid/ready output port. It replaces the fixed 10-bit and 32-bit generators. Width, default polynomial, default seed and bits advanced per word are compile-time parameters. Seed and polynomial can be reloaded at run time. Words feed the traffic and address generators of the test fabric; the consumer pulls one word per handshake.

## Interface
- WIDTH, 32: LFSR and output word width; legal range 4..64.
- TAPS, 32'h0040_0007: reset Galois tap mask (bit i set means feedback XORs into bit i). The default encodes 1+x+x^2+x^22+x^32.
- SEED, all ones: reset and fallback state; must be nonzero.
- STEPS, 1: LFSR advances per output word; legal range 1..WIDTH, unrolled combinationally.
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  generation enable; when low, no new word is produced.
- seed_load  in  1  single-cycle strobe; loads seed_in.
- seed_in  in  WIDTH  new LFSR state.
- taps_load  in  1  single-cycle strobe; loads taps_in.
- taps_in  in  WIDTH  new tap mask.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  current pseudo-random word.
- lockup  out  1  sticky flag: an all-zero seed was rejected.

## Operation
- One step: nxt(s) = {s[WIDTH-2:0],1'b0} ^ (s[WIDTH-1] ? taps : 0). An advance applies nxt STEPS times.
- Registers: state, taps, out_data, out_valid, lockup.
- Slot free condition: the slot is free when !out_valid, or when out_valid && out_ready (fire).
- Produce (slot free, en=1, no load this cycle):
  - out_data <= state
  - state <= nxt^STEPS(state)
  - out_valid <= 1
- Slot free with en=0: out_valid <= 0. state and out_data are held.
- Stall (out_valid && !out_ready): out_data, out_valid and state are held, whatever en is.
- seed_load: has priority over produce.
  - seed_in != 0: state <= seed_in and lockup <= 0.
  - seed_in == 0: state <= SEED and lockup <= 1.
  - The output is flushed: out_valid <= 0 in the same edge. A word presented in that cycle counts as not consumed, even if out_ready=1.
- taps_load: taps <= taps_in | 1 (bit 0 is forced so the state can never reach zero). It flushes the output the same way as seed_load.
- seed_load and taps_load together: both take effect. The first word after the load is seed_in and later words use the new taps.
- lockup is cleared only by rstn or by a nonzero seed_load.
- The sequence is not guaranteed maximal-length for arbitrary taps. Only the user-supplied polynomial sets the period.

## Timing
- Reset values (async assert, sync-released by the system):
  - state = SEED
  - taps = TAPS | 1
  - out_data = 0
  - out_valid = 0
  - lockup = 0
- Latency:
  - en rising with the slot empty: out_valid=1 on the next edge.
  - First word after reset or after a load is the current state (SEED or seed_in).
- Throughput: one word per cycle while en=1 and out_ready=1.
- A load strobe in cycle N flushes at edge N. The new seed is presented at edge N+1 if en=1.
- rstn asserted mid-stall: out_valid drops immediately, without waiting for a clock edge.
- The combinational path is STEPS unrolled steps, and it must close timing at STEPS=WIDTH=32.

## Test plan
- Reset, en=1, out_ready=1, WIDTH=10, TAPS=10'h009, SEED=10'h3ff -> out_data sequence 3ff, 3f7, 3e7. The word after 1023 fires equals 3ff again, and no word in between equals 3ff or 0.
- Default 32-bit parameters, continuous fire -> words ffffffff, ffbffff9. The same config with STEPS=2 -> ffffffff, then nxt(ffbffff9).
- Stall: hold out_ready=0 for 5 cycles after the first valid -> out_data is stable at 3ff and the state does not advance. Releasing out_ready resumes with 3f7, so no word is skipped or duplicated.
- seed_load with seed_in=10'h155 while out_valid=1 and out_ready=1 -> the next edge gives out_valid=0 and the following edge gives out_data=155. seed_in=0 -> lockup=1 and the next word is 3ff. A later seed_in=1 clears lockup.
- taps_load taps_in=10'h008 (bit 0 clear) with simultaneous seed_load 10'h200 -> effective taps 009. Words are 200, then 009.
- en toggled 1-0-1 with out_ready=1 -> out_valid drops for exactly the cycles where en=0. Assert rstn mid-sequence -> all outputs return to their reset values asynchronously.
